lfsr_checker: RTL and testbench

Serial PRBS checker for the team's 32-bit Fibonacci LFSR sequence (taps 32, 30, 26, 25). It is the receiving end of the random-stream path:
- it seeds itself from the incoming bits, verifies the prediction, and declares lock;
- it then counts bit errors, dropping and re-acquiring lock when the error density exceeds a threshold.

It sits on the test and debug side of the datapath, next to the generator, and is observed by software through its counters.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_err_window.sv | 51 +++++
 rtl/lfsr_checker.sv | 164 ++++++++++++++++
 tb/tb_lfsr_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit Fibonacci PRBS generator/checker pair.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 32;

    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 29;
    localparam int unsigned TAP_C = 25;
    localparam int unsigned TAP_D = 24;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Error-density window: trips when ERR_THRESH errors land inside one WINDOW of ticks.
module lfsr_err_window #(
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned ERR_THRESH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic err_i,
    input  logic clr_i,
    output logic trip_c_o
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d, cnt_inc_c;
    logic [ERR_W-1:0] win_err_q, win_err_d;

    assign cnt_inc_c = win_cnt_q + CNT_W'(1);
    // Combinational so the owner can leave lock on the very edge sampling the error.
    assign trip_c_o  = tick_i && err_i && (win_err_q >= ERR_W'(ERR_THRESH - 1));

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (clr_i) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (tick_i) begin
            if (trip_c_o || (cnt_inc_c == CNT_W'(WINDOW))) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = cnt_inc_c;
                win_err_d = win_err_q + ERR_W'(err_i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-seeds from the stream, verifies, locks, then counts bit errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned VERIFY_BITS = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned ERR_THRESH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid_i,
    input  logic        in_bit_i,
    input  logic        clear_errs_i,
    output logic        locked_o,
    output logic        err_pulse_o,
    output logic [15:0] err_count_o,
    output logic [31:0] bit_count_o,
    output logic [7:0]  relock_count_o
);

    localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
    localparam int unsigned MATCH_W = $clog2(VERIFY_BITS + 1);
    localparam int unsigned ERRC_W  = 16;
    localparam int unsigned BITC_W  = 32;
    localparam int unsigned RELC_W  = 8;

    chk_state_e          state_q, state_d;
    logic [LFSR_W-1:0]   s_q, s_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [ERRC_W-1:0]   err_count_q, err_count_d;
    logic [BITC_W-1:0]   bit_count_q, bit_count_d;
    logic [RELC_W-1:0]   relock_q, relock_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;

    logic                pred_c;
    logic                mismatch_c;
    logic [LFSR_W-1:0]   shift_in_c;
    logic [LFSR_W-1:0]   shift_pred_c;
    logic                win_tick_c;
    logic                trip_c;

    assign pred_c       = lfsr_pred(s_q);
    assign mismatch_c   = in_bit_i ^ pred_c;
    assign shift_in_c   = {s_q[LFSR_W-2:0], in_bit_i};
    assign shift_pred_c = {s_q[LFSR_W-2:0], pred_c};
    assign win_tick_c   = in_valid_i && (state_q == LOCKED);

    lfsr_err_window #(
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_window (
        .clock    (clock),
        .reset    (reset),
        .tick_i   (win_tick_c),
        .err_i    (mismatch_c),
        .clr_i    (state_q != LOCKED),
        .trip_c_o (trip_c)
    );

    // Next-state, LFSR advance and counter updates; nothing moves without in_valid.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        relock_d    = relock_q;
        err_pulse_d = 1'b0;

        if (in_valid_i) begin
            unique case (state_q)
                SEED: begin
                    s_d = shift_in_c;
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        fill_d = '0;
                        if (shift_in_c != '0) begin
                            state_d = VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    s_d = shift_pred_c;
                    if (!mismatch_c) begin
                        if (match_q == MATCH_W'(VERIFY_BITS - 1)) begin
                            match_d = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d = SEED;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    s_d         = shift_pred_c;
                    bit_count_d = bit_count_q + BITC_W'(1);
                    if (mismatch_c) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERRC_W'(1);
                        end
                    end
                    if (trip_c) begin
                        state_d = SEED;
                        fill_d  = '0;
                        match_d = '0;
                        if (relock_q != '1) begin
                            relock_d = relock_q + RELC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end

        if (clear_errs_i) begin
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= SEED;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            relock_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            relock_q    <= relock_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked_o       = locked_q;
    assign err_pulse_o    = err_pulse_q;
    assign err_count_o    = err_count_q;
    assign bit_count_o    = bit_count_q;
    assign relock_count_o = relock_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed + randomized bench for lfsr_checker against a sequence-recurrence reference model.
module tb_lfsr_checker;

    logic        clock;
    logic        reset;
    logic        in_valid_i;
    logic        in_bit_i;
    logic        clear_errs_i;
    logic        locked_o;
    logic        err_pulse_o;
    logic [15:0] err_count_o;
    logic [31:0] bit_count_o;
    logic [7:0]  relock_count_o;

    int checks = 0;
    int errors = 0;

    lfsr_checker dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid_i     (in_valid_i),
        .in_bit_i       (in_bit_i),
        .clear_errs_i   (clear_errs_i),
        .locked_o       (locked_o),
        .err_pulse_o    (err_pulse_o),
        .err_count_o    (err_count_o),
        .bit_count_o    (bit_count_o),
        .relock_count_o (relock_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Generator: emits its MSB, feeds back the tap XOR at the LSB.
    logic [31:0] g;

    // Reference model: the checker's expected sequence as a bit history obeying
    // b[n] = b[n-32] ^ b[n-30] ^ b[n-26] ^ b[n-25].
    bit          h[$];
    int          m_mode;   // 0 seed, 1 verify, 2 locked
    int          m_fill, m_match, m_wcnt, m_werr;
    int          m_err, m_relock;
    longint      m_bits;
    bit          m_pulse;

    task automatic gen_bit(output logic b);
        logic fb;
        b  = g[31];
        fb = g[31] ^ g[29] ^ g[25] ^ g[24];
        g  = {g[30:0], fb};
    endtask

    task automatic model_reset();
        h.delete();
        for (int i = 0; i < 32; i++) h.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
        m_err = 0; m_relock = 0; m_bits = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic clr);
        int  n;
        bit  p;
        bit  nz;
        m_pulse = 1'b0;
        if (v) begin
            n = h.size();
            p = h[n-32] ^ h[n-30] ^ h[n-26] ^ h[n-25];
            if (m_mode == 0) begin
                h.push_back(b);
                void'(h.pop_front());
                m_fill++;
                if (m_fill == 32) begin
                    m_fill = 0;
                    nz = 1'b0;
                    foreach (h[k]) nz |= h[k];
                    if (nz) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                h.push_back(p);
                void'(h.pop_front());
                if (b == p) begin
                    m_match++;
                    if (m_match == 32) begin
                        m_match = 0;
                        m_mode  = 2;
                    end
                end else begin
                    m_mode = 0; m_fill = 0; m_match = 0;
                end
            end else begin
                h.push_back(p);
                void'(h.pop_front());
                m_bits++;
                m_wcnt++;
                if (b != p) begin
                    m_pulse = 1'b1;
                    if (m_err < 65535) m_err++;
                    m_werr++;
                end
                if (m_werr >= 8) begin
                    m_mode = 0; m_fill = 0; m_match = 0;
                    m_wcnt = 0; m_werr = 0;
                    if (m_relock < 255) m_relock++;
                end else if (m_wcnt == 64) begin
                    m_wcnt = 0; m_werr = 0;
                end
            end
        end
        if (clr) m_err = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},    32'(locked_o),       32'(m_mode == 2));
        check({tag, ".err_pulse"}, 32'(err_pulse_o),    32'(m_pulse));
        check({tag, ".err_count"}, 32'(err_count_o),    32'(m_err));
        check({tag, ".bit_count"}, bit_count_o,         32'(m_bits));
        check({tag, ".relock"},    32'(relock_count_o), 32'(m_relock));
    endtask

    task automatic step(input logic v, input logic b, input logic clr, input string tag);
        @(negedge clock);
        in_valid_i   = v;
        in_bit_i     = b;
        clear_errs_i = clr;
        @(posedge clock);
        model_step(v, b, clr);
        #1;
        check_all(tag);
    endtask

    // Valid clean bit from the generator, optionally inverted.
    task automatic send(input logic flip, input logic clr, input string tag);
        logic b;
        gen_bit(b);
        step(1'b1, b ^ flip, clr, tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid_i = 1'b0; in_bit_i = 1'b0; clear_errs_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic acquire(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (m_mode == 2) break;
            send(1'b0, 1'b0, tag);
        end
        check({tag, ".acquired"}, 32'(m_mode), 32'd2);
    endtask

    initial begin
        int  nvalid;
        bit  seen;
        logic b;
        logic v;

        reset = 1'b1;
        in_valid_i = 1'b0; in_bit_i = 1'b0; clear_errs_i = 1'b0;
        g = 32'h8EAF696C;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Clean stream: lock on the 64th valid bit exactly.
        for (int i = 0; i < 70; i++) begin
            send(1'b0, 1'b0, "clean");
            if (i == 62) check("clean.pre_lock", 32'(locked_o), 32'd0);
            if (i == 63) check("clean.lock_at_64", 32'(locked_o), 32'd1);
        end
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0, "clean_run");
        check("clean.bits", bit_count_o, 32'd26);

        // Single inverted bit while locked.
        send(1'b1, 1'b0, "single_err");
        check("single_err.pulse", 32'(err_pulse_o), 32'd1);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, "single_after");
        check("single_err.count", 32'(err_count_o), 32'd1);
        check("single_err.still_locked", 32'(locked_o), 32'd1);

        // Run out the current window, then a burst of 8 errors in a fresh one.
        for (int i = 0; i < 27; i++) send(1'b0, 1'b0, "win_fill");
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0, "burst");
            if (i == 6) check("burst.locked_at_7", 32'(locked_o), 32'd1);
        end
        check("burst.unlocked", 32'(locked_o), 32'd0);
        check("burst.relock_count", 32'(relock_count_o), 32'd1);
        for (int i = 0; i < 64; i++) begin
            send(1'b0, 1'b0, "relock");
            if (i == 62) check("relock.pre", 32'(locked_o), 32'd0);
        end
        check("relock.locked", 32'(locked_o), 32'd1);
        check("relock.err_count", 32'(err_count_o), 32'd9);

        // Clear coinciding with an error: clear wins.
        send(1'b1, 1'b1, "clr_vs_err");
        check("clr_vs_err.count", 32'(err_count_o), 32'd0);

        // All-zero input never locks.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0, "zeros");
            seen |= locked_o;
        end
        check("zeros.never_locked", 32'(seen), 32'd0);

        // Mismatch during VERIFY restarts acquisition from scratch.
        do_reset();
        for (int i = 0; i < 40; i++) send(1'b0, 1'b0, "verify_pre");
        send(1'b1, 1'b0, "verify_bad");
        nvalid = 0;
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 1'b0, "verify_reacq");
            nvalid++;
            if (locked_o) break;
        end
        check("verify_mismatch.relock_bits", 32'(nvalid), 32'd64);
        check("verify_mismatch.no_err", 32'(err_count_o), 32'd0);

        // Random in_valid gaps during acquisition.
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) begin
                gen_bit(b);
                nvalid++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(v, b, 1'b0, "gaps");
            if (locked_o) break;
        end
        check("gaps.lock_valid_bits", 32'(nvalid), 32'd64);

        // Randomized errors, gaps and clears while running.
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                gen_bit(b);
                b ^= ($urandom_range(0, 19) == 0);
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(v, b, ($urandom_range(0, 49) == 0), "random");
        end

        // Saturation of err_count.
        acquire("sat_acq");
        force dut.err_count_q = 16'hFFFF;
        #1;
        release dut.err_count_q;
        m_err = 65535;
        send(1'b1, 1'b0, "sat_err");
        check("sat.count", 32'(err_count_o), 32'h0000FFFF);

        // Asynchronous reset off the clock edge.
        acquire("rst_acq");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clock);
        check_all("async_reset_hold");
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
